// File: rtl/mul7_pkg.sv
// Shared definitions for the divide-by-7 scanner and its residue engine.
// Contents: scanner state encoding, default operand width, the modulus, and
// helpers for the bit-serial residue recurrence r = (2r + bit) mod 7.
package mul7_pkg;

    localparam int unsigned MUL7_DW  = 32;
    localparam int unsigned MUL7_MOD = 7;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StSend,
        StWait,
        StDone
    } scan_state_e;

    // One MSB-first step: r' = (2r + b) mod 7. 2r + b never exceeds 13,
    // so a single conditional subtract is enough.
    function automatic logic [2:0] mod7_step(input logic [2:0] r, input logic b);
        logic [3:0] t;
        t = {r, b};
        if (t >= 4'(MUL7_MOD)) begin
            t = t - 4'(MUL7_MOD);
        end
        return t[2:0];
    endfunction

    // r' = (r + 1) mod 7
    function automatic logic [2:0] mod7_inc(input logic [2:0] r);
        return (r == 3'(MUL7_MOD - 1)) ? 3'd0 : r + 3'd1;
    endfunction

endpackage

// File: rtl/mod7_serial.sv
// Bit-serial mod-7 residue engine.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load_i        overwrite the residue with load_val_i (has priority)
//   load_val_i    residue value to load
//   shift_i       shift bit_i in, MSB first: r = (2r + bit) mod 7
//   bit_i         next operand bit
//   r_o           current residue
module mod7_serial
    import mul7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       shift_i,
    input  logic       bit_i,
    output logic [2:0] r_o
);

    logic [2:0] r_q, r_d;

    always_comb begin
        r_d = r_q;
        if (load_i) begin
            r_d = load_val_i;
        end else if (shift_i) begin
            r_d = mod7_step(r_q, bit_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/mul7_scanner.sv
// Operand sequencer and result collector for the divide-by-7 serial detector.
// Issues base, base+1, ... over the det_src/det_src_valid/det_ready handshake,
// collects each det_res verdict, and reports the hit count and last hit.
// Optional self-check (macro MUL7_SCAN_SELFCHECK_EN): computes base mod 7 in a
// PREP phase, tracks a running residue and counts verdicts that disagree.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   start_i            run request, honoured only in IDLE
//   base_i, num_i      first operand and operand count, sampled on start
//   det_src_o          operand to detector, det_src_valid_o its valid
//   det_ready_i        detector ready; det_res_i/det_res_valid_i its verdict
//   busy_o, done_o     run in progress / one-cycle end-of-run pulse
//   hit_count_o        operands judged divisible, last_hit_o last such operand
//   err_count_o        self-check disagreements (0 without self-check)
module mul7_scanner
    import mul7_pkg::*;
#(
    parameter int unsigned DW = MUL7_DW,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] base_i,
    input  logic [CW-1:0] num_i,
    output logic [DW-1:0] det_src_o,
    output logic          det_src_valid_o,
    input  logic          det_ready_i,
    input  logic          det_res_i,
    input  logic          det_res_valid_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] hit_count_o,
    output logic [DW-1:0] last_hit_o,
    output logic [CW-1:0] err_count_o
);

    localparam logic [CW-1:0] CntMax = '1;

    scan_state_e   state_q, state_d;
    logic [DW-1:0] cur_q, cur_d;
    logic [CW-1:0] left_q, left_d;
    logic [CW-1:0] hit_q, hit_d;
    logic [DW-1:0] last_q, last_d;
    logic [DW-1:0] src_q, src_d;
    logic          src_valid_q, src_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          skip_q, skip_d;
    logic          accept;
    logic          capture;

`ifdef MUL7_SCAN_SELFCHECK_EN
    localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] err_q, err_d;
    logic          res_load;
    logic [2:0]    res_load_val;
    logic          res_shift;
    logic          res_bit;
    logic [2:0]    res_r;
`endif

    // A start landing on the done-pulse cycle is dropped even though the FSM is
    // already back in IDLE.
    assign accept  = (state_q == StIdle) && start_i && !done_q;
    // The first WAIT cycle carries the detector's stale previous verdict.
    assign capture = (state_q == StWait) && !skip_q && det_res_valid_i;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        left_d  = left_q;
        hit_d   = hit_q;
        last_d  = last_q;
        src_d   = src_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        skip_d  = skip_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cur_d  = base_i;
                    left_d = num_i;
                    hit_d  = '0;
                    last_d = '0;
                    if (num_i == '0) begin
                        state_d = StDone;
                    end else begin
                        busy_d = 1'b1;
`ifdef MUL7_SCAN_SELFCHECK_EN
                        state_d = StPrep;
`else
                        state_d = StSend;
`endif
                    end
                end
            end
            StPrep: begin
`ifdef MUL7_SCAN_SELFCHECK_EN
                if (idx_q == '0) begin
                    state_d = StSend;
                end
`else
                state_d = StSend;
`endif
            end
            StSend: begin
                if (det_ready_i) begin
                    state_d = StWait;
                    skip_d  = 1'b1;
                end
            end
            StWait: begin
                skip_d = 1'b0;
                if (capture) begin
                    if (det_res_i) begin
                        if (hit_q != CntMax) begin
                            hit_d = hit_q + CW'(1);
                        end
                        last_d = cur_q;
                    end
                    cur_d   = cur_q + DW'(1);
                    left_d  = left_q - CW'(1);
                    state_d = (left_q == CW'(1)) ? StDone : StSend;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state so they line up with the state.
        src_valid_d = (state_d == StSend);
        if (state_d == StSend) begin
            src_d = cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            left_q      <= '0;
            hit_q       <= '0;
            last_q      <= '0;
            src_q       <= '0;
            src_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            left_q      <= left_d;
            hit_q       <= hit_d;
            last_q      <= last_d;
            src_q       <= src_d;
            src_valid_q <= src_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            skip_q      <= skip_d;
        end
    end

`ifdef MUL7_SCAN_SELFCHECK_EN
    always_comb begin
        idx_d        = idx_q;
        err_d        = err_q;
        res_load     = 1'b0;
        res_load_val = '0;
        res_shift    = 1'b0;
        res_bit      = 1'b0;
        if (accept) begin
            idx_d    = IW'(DW - 1);
            err_d    = '0;
            res_load = 1'b1;
        end
        if (state_q == StPrep) begin
            res_shift = 1'b1;
            res_bit   = cur_q[idx_q];
            idx_d     = idx_q - IW'(1);
        end
        if (capture) begin
            if ((det_res_i != (res_r == 3'd0)) && (err_q != CntMax)) begin
                err_d = err_q + CW'(1);
            end
            // 2^DW mod 7 is not 1, so the running residue restarts at the wrap.
            res_load     = 1'b1;
            res_load_val = (cur_d == '0) ? 3'd0 : mod7_inc(res_r);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
            err_q <= '0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    mod7_serial u_mod7_serial (
        .clk        (clk),
        .rst        (rst),
        .load_i     (res_load),
        .load_val_i (res_load_val),
        .shift_i    (res_shift),
        .bit_i      (res_bit),
        .r_o        (res_r)
    );

    assign err_count_o = err_q;
`else
    assign err_count_o = '0;
`endif

    assign det_src_o       = src_q;
    assign det_src_valid_o = src_valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign hit_count_o     = hit_q;
    assign last_hit_o      = last_q;

endmodule

// File: doc/mul7_scanner.md
# mul7_scanner

Operand sequencer and result collector for the divide-by-7 serial detector. Receives a base value and a count, then issues `base, base+1, …` one at a time over the detector's `src/src_valid/ready` handshake. Collects each `res/res_valid` result and reports the number of multiples of 7 and the last one found. Sits between the switch/button front end and the detector on the lab top level.

## Interface
Parameters:
- `DW`, 32: operand width; must match the detector input.
- `CW`, 8: width of the count, hit counter and error counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request; honored only in IDLE.
- `base` in DW: first operand; sampled when `start` is accepted.
- `num` in CW: number of operands to issue; sampled when `start` is accepted.
- `det_src` out DW: operand to the detector.
- `det_src_valid` out 1: operand valid.
- `det_ready` in 1: detector idle and ready to accept.
- `det_res` in 1: detector verdict (1 = divisible by 7).
- `det_res_valid` in 1: detector verdict valid.
- `busy` out 1: high from start acceptance until DONE.
- `done` out 1: one-cycle pulse at the end of a run.
- `hit_count` out CW: count of operands judged divisible in the current or last run.
- `last_hit` out DW: most recent operand judged divisible; 0 if there were none.
- `err_count` out CW: self-check mismatches (see Configuration).

## Operation
- States: IDLE, PREP, SEND, WAIT, DONE.
- **IDLE**
  - `start`=1 latches `base` into `cur` and `num` into `left`.
  - Clears `hit_count`, `last_hit` and `err_count`.
  - Goes to PREP. If `num`=0, goes to DONE instead.
- **PREP** (self-check only; otherwise passes straight to SEND)
  - Computes `cur mod 7` bit-serially, MSB first, with `r = (2r + bit) mod 7`.
  - Takes 32 cycles, then goes to SEND.
- **SEND**
  - Drives `det_src=cur` and `det_src_valid=1`.
  - The transfer happens on the first cycle where `det_ready`=1; then go to WAIT.
- **WAIT**
  - Holds `det_src_valid=0`.
  - Ignores `det_res_valid` during the first cycle after the transfer, because the detector's previous result is stale.
  - On the next cycle with `det_res_valid`=1, captures `det_res`:
    - If `det_res`=1, increment `hit_count` (saturating at 2^CW−1) and set `last_hit=cur`.
  - Then set `cur=cur+1` (wrapping mod 2^DW) and `left=left−1`.
  - Goes to SEND if `left`≠0, otherwise to DONE.
- **DONE**: pulse `done`, drop `busy`, return to IDLE. Counters hold until the next accepted start.
- Simultaneous events:
  - `start` while busy is ignored.
  - `start` in the same cycle as the DONE pulse is ignored. It is accepted only from IDLE.
- Reset mid-run: returns to IDLE immediately.
  - An in-flight detector operation is abandoned.
  - The detector should be reset alongside this block.

## Timing
- Reset values:
  - `det_src`=0, `det_src_valid`=0, `busy`=0, `done`=0.
  - `hit_count`=0, `last_hit`=0, `err_count`=0.
  - State is IDLE.
- All outputs are registered.
- Per operand: 1 SEND cycle (if `det_ready` is high), then the detector latency (~33 cycles), then 1 capture cycle.
- `busy` rises the cycle after `start` is accepted.
- With `num`=0, `done` rises 1 cycle after `start`, i.e. 2 cycles after the start edge.

## Configuration
- Macro: `MUL7_SCAN_SELFCHECK_EN`.
- **Defined**
  - Enables PREP and a running residue `r`:
    - `r = (r+1) mod 7` after each operand.
    - `r` is forced to 0 when `cur` wraps to 0, because 2^32 ≡ 4 (mod 7) breaks the simple increment.
  - On each capture, if `det_res ≠ (r==0)`, increment `err_count` (saturating).
- **Undefined**
  - PREP and the residue logic are removed.
  - `err_count` is tied to 0.
  - Runs take 32 fewer cycles.

## Structure
- Shared package `mul7_pkg`:
  - State encoding enum (IDLE…DONE).
  - `MUL7_DW`=32.
  - Modulus constant 7.
- Sub-module `mod7_serial`: bit-serial residue engine (load, shift-in bit, r out).
  - Instantiated only under `MUL7_SCAN_SELFCHECK_EN`.
  - Reusable for the detector's golden model.

## Test plan
- base=0, num=8, behavioral detector → `hit_count`=2, `last_hit`=7, `err_count`=0, one `done` pulse.
- base=14, num=1 → `hit_count`=1, `last_hit`=14.
- base=0xFFFFFFFC, num=8 (wrap) → `hit_count`=2, `last_hit`=0, `err_count`=0.
  - Covers 0xFFFFFFFC ≡ 0 and the residue forced to 0 at the wrap.
- num=0 → `done` 2 cycles after the start edge, `busy` never high, `hit_count`=0.
  - A second `start` during a run is ignored; `hit_count` is unchanged.
- Stub detector that always returns `res`=1, base=1, num=7, macro defined → `hit_count`=7, `err_count`=6.
  - Hold `det_ready` low 5 cycles in SEND → `det_src_valid` held, no capture.
- Pull `rst`=0 during WAIT → next cycle state IDLE, `busy`=0, all counters 0, `det_src_valid`=0.
